aes_ctr_incr_gen: RTL and testbench

Parametrised successor of the AES CTR-mode counter FSM. Increments a wide counter one slice per cycle, with configurable counter width and slice size. Adds a programmable step, a GCM-style partial-width mode (inc32), a wrap flag, and a sparse-encoded FSM with terminal error state. Sits between the AES control FSM and the multi-slice IV/counter register, which it reads and writes one slice per cycle.

---
 rtl/aes_pkg.sv | 15 +
 rtl/aes_ctr_slice_add.sv | 23 ++
 rtl/aes_ctr_incr_gen.sv | 143 ++++++++++++++
 tb/tb_aes_ctr_incr_gen.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and default sizing for the AES CTR counter increment generator.
package aes_pkg;

    localparam int unsigned CtrWidthDefault  = 128;
    localparam int unsigned SliceSizeDefault = 16;
    localparam int unsigned PartWidthDefault = 32;

    // Sparse encodings, pairwise Hamming distance >= 3 so a single upset cannot reach a legal state.
    typedef enum logic [5:0] {
        CTR_IDLE  = 6'b001110,
        CTR_INCR  = 6'b110101,
        CTR_ERROR = 6'b100011
    } aes_ctr_gen_e;

endpackage

// File: rtl/aes_ctr_slice_add.sv
// One slice of a wide counter add: slice + (step or carry), with carry out.
module aes_ctr_slice_add #(
    parameter int unsigned SliceSize = 16
) (
    input  logic [SliceSize-1:0] slice_i,
    input  logic [SliceSize-1:0] step_i,
    input  logic                 carry_i,
    input  logic                 sel_step_i,
    output logic [SliceSize-1:0] sum_o,
    output logic                 carry_o
);

    logic [SliceSize-1:0] addend;
    logic [SliceSize:0]   sum;

    always_comb begin
        addend = sel_step_i ? step_i : {{(SliceSize-1){1'b0}}, carry_i};
        sum    = {1'b0, slice_i} + {1'b0, addend};
        sum_o  = sum[SliceSize-1:0];
        carry_o = sum[SliceSize];
    end

endmodule

// File: rtl/aes_ctr_incr_gen.sv
// Slice-serial CTR counter incrementer with programmable step and inc32-style partial mode.
// Macro AES_CTR_EARLY_EXIT_EN: stop once carry dies out; latency then depends on data (not constant-time).
module aes_ctr_incr_gen
    import aes_pkg::*;
#(
    parameter int unsigned CtrWidth  = CtrWidthDefault,
    parameter int unsigned SliceSize = SliceSizeDefault,
    parameter int unsigned PartWidth = PartWidthDefault,
    localparam int unsigned NumSlices = CtrWidth / SliceSize,
    localparam int unsigned IdxWidth  = (NumSlices > 1) ? $clog2(NumSlices) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 incr_i,
    input  logic                 mode_part_i,
    input  logic [SliceSize-1:0] step_i,
    output logic                 ready_o,
    output logic                 done_o,
    output logic                 wrap_o,
    input  logic                 incr_err_i,
    input  logic                 mr_err_i,
    output logic                 alert_o,
    output logic [IdxWidth-1:0]  ctr_slice_idx_o,
    input  logic [SliceSize-1:0] ctr_slice_i,
    output logic [SliceSize-1:0] ctr_slice_o,
    output logic                 ctr_we_o
);

    localparam logic [IdxWidth-1:0] LastFull = IdxWidth'(NumSlices - 1);
    localparam logic [IdxWidth-1:0] LastPart = IdxWidth'(PartWidth / SliceSize - 1);

    aes_ctr_gen_e         state_q, state_d;
    logic [IdxWidth-1:0]  idx_q, idx_d;
    logic                 carry_q, carry_d;
    logic [SliceSize-1:0] step_q, step_d;
    logic                 mode_q, mode_d;

    logic [SliceSize-1:0] sum;
    logic                 sum_carry;
    logic [IdxWidth-1:0]  last_idx;
    logic                 early_exit;

    aes_ctr_slice_add #(
        .SliceSize(SliceSize)
    ) u_slice_add (
        .slice_i   (ctr_slice_i),
        .step_i    (step_q),
        .carry_i   (carry_q),
        .sel_step_i(idx_q == '0),
        .sum_o     (sum),
        .carry_o   (sum_carry)
    );

    assign last_idx = mode_q ? LastPart : LastFull;

`ifdef AES_CTR_EARLY_EXIT_EN
    assign early_exit = (idx_q != '0) && !carry_q;
`else
    assign early_exit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        step_d      = step_q;
        mode_d      = mode_q;
        ready_o     = 1'b0;
        done_o      = 1'b0;
        wrap_o      = 1'b0;
        alert_o     = 1'b0;
        ctr_we_o    = 1'b0;
        ctr_slice_o = sum;

        case (state_q)
            CTR_IDLE: begin
                ready_o = 1'b1;
                if (incr_i) begin
                    step_d  = step_i;
                    mode_d  = mode_part_i;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    state_d = CTR_INCR;
                end
            end
            CTR_INCR: begin
                if (early_exit) begin
                    done_o  = 1'b1;
                    idx_d   = '0;
                    state_d = CTR_IDLE;
                end else begin
                    ctr_we_o = 1'b1;
                    carry_d  = sum_carry;
                    idx_d    = idx_q + IdxWidth'(1);
                    if (idx_q == last_idx) begin
                        done_o  = 1'b1;
                        wrap_o  = sum_carry;
                        idx_d   = '0;
                        state_d = CTR_IDLE;
                    end
                end
            end
            CTR_ERROR: begin
                alert_o = 1'b1;
            end
            default: begin
                alert_o = 1'b1;
                state_d = CTR_ERROR;
            end
        endcase

        // Integrity errors override any transition, but this cycle's write still follows state_q.
        if (incr_err_i || mr_err_i) begin
            state_d = CTR_ERROR;
        end
    end

    assign ctr_slice_idx_o = idx_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= CTR_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            step_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
        end
    end

`ifndef SYNTHESIS
    a_alert_legal : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !alert_o |-> (state_q == CTR_IDLE || state_q == CTR_INCR));
    a_we_incr : assert property (@(posedge clk_i) disable iff (!rst_ni)
        ctr_we_o |-> (state_q == CTR_INCR));
`endif

endmodule

// File: tb/tb_aes_ctr_incr_gen.sv
// Scoreboard bench for aes_ctr_incr_gen: random and directed increments against a 128-bit arithmetic model.
module tb_aes_ctr_incr_gen;

    localparam int NSL     = 8;
    localparam int SL      = 16;
    localparam int PART_SL = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        incr_i = 1'b0;
    logic        mode_part_i = 1'b0;
    logic [15:0] step_i = '0;
    logic        ready_o, done_o, wrap_o, alert_o, ctr_we_o;
    logic        incr_err_i = 1'b0;
    logic        mr_err_i = 1'b0;
    logic [2:0]  ctr_slice_idx_o;
    logic [15:0] ctr_slice_i, ctr_slice_o;

    logic [127:0] ctr_q = '0;
    logic         load_req = 1'b0;
    logic [127:0] load_val = '0;

    typedef struct {
        int          idx;
        logic [15:0] val;
    } wr_t;

    wr_t wr_q[$];
    bit  done_q[$];
    wr_t mw;
    bit  mwrap;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    aes_ctr_incr_gen dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .incr_i         (incr_i),
        .mode_part_i    (mode_part_i),
        .step_i         (step_i),
        .ready_o        (ready_o),
        .done_o         (done_o),
        .wrap_o         (wrap_o),
        .incr_err_i     (incr_err_i),
        .mr_err_i       (mr_err_i),
        .alert_o        (alert_o),
        .ctr_slice_idx_o(ctr_slice_idx_o),
        .ctr_slice_i    (ctr_slice_i),
        .ctr_slice_o    (ctr_slice_o),
        .ctr_we_o       (ctr_we_o)
    );

    // Behavioural model of the external multi-slice counter register.
    assign ctr_slice_i = ctr_q[int'(ctr_slice_idx_o)*SL +: SL];

    always @(posedge clk_i) begin
        if (load_req) ctr_q <= load_val;
        else if (ctr_we_o === 1'b1) ctr_q[int'(ctr_slice_idx_o)*SL +: SL] <= ctr_slice_o;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] model_new(input logic [127:0] old, input logic [15:0] step,
                                               input bit part, output bit wrap);
        logic [128:0] s;
        logic [32:0]  p;
        if (!part) begin
            s = {1'b0, old} + {113'b0, step};
            wrap = s[128];
            return s[127:0];
        end
        p = {1'b0, old[31:0]} + {17'b0, step};
        wrap = p[32];
        return {old[127:32], p[31:0]};
    endfunction

`ifdef AES_CTR_EARLY_EXIT_EN
    function automatic bit carry_into(input logic [127:0] old, input logic [15:0] step, input int i);
        logic [128:0] lo, s;
        lo = {1'b0, old} & ((129'd1 << (SL*i)) - 129'd1);
        s  = lo + {113'b0, step};
        return s[SL*i];
    endfunction
`endif

    // Monitor: every write and every done pulse must match the next scoreboard entry.
    initial begin
        forever begin
            @(negedge clk_i);
            if (ctr_we_o === 1'b1) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: idx=%0d val=%h, none expected", ctr_slice_idx_o, ctr_slice_o);
                end else begin
                    mw = wr_q.pop_front();
                    chk("write_idx", 128'(ctr_slice_idx_o), 128'(mw.idx));
                    chk("write_val", 128'(ctr_slice_o), 128'(mw.val));
                end
            end
            if (done_o === 1'b1) begin
                if (done_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: wrap=%b, none expected", wrap_o);
                end else begin
                    mwrap = done_q.pop_front();
                    chk("wrap", 128'(wrap_o), 128'(mwrap));
                end
            end
        end
    end

    task automatic load_ctr(input logic [127:0] v);
        @(posedge clk_i); #1;
        load_req = 1'b1;
        load_val = v;
        @(posedge clk_i); #1;
        load_req = 1'b0;
    endtask

    task automatic run_op(input logic [127:0] old, input logic [15:0] step, input bit part);
        logic [127:0] exp;
        bit wr;
        int last, nw, lat, cnt;
        wr_t w;
        exp  = model_new(old, step, part, wr);
        last = part ? PART_SL - 1 : NSL - 1;
        nw   = last + 1;
`ifdef AES_CTR_EARLY_EXIT_EN
        nw = 1;
        while (nw <= last && carry_into(old, step, nw)) nw++;
`endif
        lat = (nw == last + 1) ? nw : nw + 1;
        load_ctr(old);
        incr_i = 1'b1;
        step_i = step;
        mode_part_i = part;
        for (int i = 0; i < nw; i++) begin
            w.idx = i;
            w.val = exp[i*SL +: SL];
            wr_q.push_back(w);
        end
        done_q.push_back(wr);
        @(negedge clk_i);
        chk("ready_idle", 128'(ready_o), 128'(1));
        @(posedge clk_i); #1;
        incr_i = 1'b0;
        step_i = 16'($urandom);
        mode_part_i = 1'($urandom);
        cnt = 0;
        do begin
            @(negedge clk_i);
            cnt++;
        end while (done_o !== 1'b1 && cnt < 40);
        if (done_o !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: no done after %0d cycles, expected after %0d", cnt, lat);
        end else begin
            chk("latency", 128'(cnt), 128'(lat));
        end
        @(posedge clk_i); #1;
        chk("counter_value", ctr_q, exp);
        @(negedge clk_i);
        chk("ready_after", 128'(ready_o), 128'(1));
    endtask

    initial begin
        logic [127:0] old;
        logic [15:0]  st;
        wr_t w;

        // Reset state.
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_ready", 128'(ready_o), 128'(1));
        chk("rst_done", 128'(done_o), 128'(0));
        chk("rst_wrap", 128'(wrap_o), 128'(0));
        chk("rst_alert", 128'(alert_o), 128'(0));
        chk("rst_we", 128'(ctr_we_o), 128'(0));
        chk("rst_idx", 128'(ctr_slice_idx_o), 128'(0));
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // Directed cases.
        run_op({112'h0, 16'hFFFF}, 16'd1, 1'b0);
        run_op({128{1'b1}}, 16'd1, 1'b0);
        run_op({128{1'b1}}, 16'd1, 1'b1);
        run_op({96'h0123_4567_89AB_CDEF_0000_0000, 16'h1234, 16'hFFFE}, 16'd5, 1'b0);
        run_op({112'h0, 16'h0001}, 16'd1, 1'b0);
        run_op({96'hFFFF_0000_FFFF_0000_1111_2222, 32'hFFFF_FFFF}, 16'd0, 1'b0);
        run_op({64'hAAAA_BBBB_CCCC_DDDD, 64'hFFFF_FFFF_FFFF_FFF0}, 16'h0020, 1'b1);

        // Randomized increments, biased towards long carry chains.
        for (int n = 0; n < 25; n++) begin
            old = {$urandom, $urandom, $urandom, $urandom};
            for (int k = 0; k < NSL; k++) if ($urandom_range(0, 1) == 1) old[k*SL +: SL] = 16'hFFFF;
            case ($urandom_range(0, 3))
                0: st = 16'd0;
                1: st = 16'd1;
                default: st = 16'($urandom);
            endcase
            run_op(old, st, 1'($urandom_range(0, 1)));
        end

        // Controller error at idx 3: terminal ERROR until reset.
        load_ctr({128{1'b1}});
        incr_i = 1'b1;
        step_i = 16'd1;
        mode_part_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w.idx = i;
            w.val = 16'h0000;
            wr_q.push_back(w);
        end
        @(posedge clk_i); #1;
        incr_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 mr_err_i = 1'b1;
        @(posedge clk_i); #1;
        mr_err_i = 1'b0;
        incr_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("err_alert", 128'(alert_o), 128'(1));
            chk("err_we", 128'(ctr_we_o), 128'(0));
            chk("err_ready", 128'(ready_o), 128'(0));
        end
        chk("err_counter", ctr_q, {{64{1'b1}}, 64'h0});
        @(posedge clk_i); #1;
        incr_i = 1'b0;
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("err_rst_alert", 128'(alert_o), 128'(0));
        chk("err_rst_ready", 128'(ready_o), 128'(1));

        // Reset mid-operation during the idx 2 cycle.
        load_ctr({128{1'b1}});
        incr_i = 1'b1;
        step_i = 16'd1;
        for (int i = 0; i < 3; i++) begin
            w.idx = i;
            w.val = 16'h0000;
            wr_q.push_back(w);
        end
        @(posedge clk_i); #1;
        incr_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("midrst_ready", 128'(ready_o), 128'(1));
        chk("midrst_idx", 128'(ctr_slice_idx_o), 128'(0));
        chk("midrst_we", 128'(ctr_we_o), 128'(0));
        repeat (3) @(posedge clk_i);
        #1 chk("midrst_counter", ctr_q, {{80{1'b1}}, 48'h0});

        chk("writes_drained", 128'(wr_q.size()), 128'(0));
        chk("dones_drained", 128'(done_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete, limit %0d ns", 2_000_000);
        $fatal(1, "timeout");
    end

endmodule
